// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// The request and its address/data are held until the one-cycle ack strobe.
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack,
        output rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack bus and stalls the front of the pipe.
// Optional feature macro MEM_TIMEOUT_EN: abort an access after TIMEOUT cycles and raise sticky err_o.
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               RegWrite_i,
    input  logic               MemToReg_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic [DATA_W-1:0]  ALUres_i,
    input  logic [DATA_W-1:0]  WriteData_i,
    input  logic [4:0]         RegisterRd_i,

    mem_access_stage_if.master mem,

    output logic               stall_o,
    output logic               RegWrite_o,
    output logic               MemToReg_o,
    output logic [DATA_W-1:0]  ALUres_o,
    output logic [DATA_W-1:0]  ReadData_o,
    output logic [4:0]         RegisterRd_o,
    output logic               err_o
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_access_stage: TIMEOUT must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_op;
    logic              is_load;
    logic              stall_raw;
    logic              req_raw;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
`endif

    assign mem_op  = MemRead_i | MemWrite_i;
    // A store wins when both Mem flags are set, so only a pure read captures data.
    assign is_load = MemRead_i & ~MemWrite_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Counts ACCESS cycles; held at zero everywhere else so it is clear on entry.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == ST_ACCESS) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        stall_raw = 1'b0;
        req_raw   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    stall_raw = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                stall_raw = 1'b1;
                req_raw   = 1'b1;
                if (mem.ack) begin
                    state_d = ST_DONE;
                    if (is_load) begin
                        rdata_d = mem.rdata;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    rdata_d = DATA_W'(32'hDEADBEEF);
                    err_d   = 1'b1;
                end
`endif
            end
            // DONE lets EX/MEM advance; it never starts a new access itself.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset gates the stall so the pipeline is released immediately, even mid-access.
    assign stall_o      = stall_raw & rst_i;
    assign mem.req      = req_raw & rst_i;
    assign mem.we       = MemWrite_i;
    assign mem.addr     = ALUres_i;
    assign mem.wdata    = WriteData_i;

    assign RegWrite_o   = RegWrite_i & ~stall_o;
    assign MemToReg_o   = MemToReg_i;
    assign ALUres_o     = ALUres_i;
    assign RegisterRd_o = RegisterRd_i;
    assign ReadData_o   = rdata_q;

`ifdef MEM_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: passthrough, load/store latency, back-to-back, reset, timeout.
module tb_mem_access_stage;

    logic        clk_i;
    logic        rst_i;
    logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALUres_i, WriteData_i;
    logic [4:0]  RegisterRd_i;
    logic        stall_o, RegWrite_o, MemToReg_o, err_o;
    logic [31:0] ALUres_o, ReadData_o;
    logic [4:0]  RegisterRd_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_stage_if #(.DATA_W(32)) mem_bus ();

    mem_access_stage #(.DATA_W(32), .TIMEOUT(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .RegWrite_i   (RegWrite_i),
        .MemToReg_i   (MemToReg_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .ALUres_i     (ALUres_i),
        .WriteData_i  (WriteData_i),
        .RegisterRd_i (RegisterRd_i),
        .mem          (mem_bus.master),
        .stall_o      (stall_o),
        .RegWrite_o   (RegWrite_o),
        .MemToReg_o   (MemToReg_o),
        .ALUres_o     (ALUres_o),
        .ReadData_o   (ReadData_o),
        .RegisterRd_o (RegisterRd_o),
        .err_o        (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_instr(input logic rw, input logic m2r, input logic mr, input logic mw,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        RegWrite_i   = rw;
        MemToReg_i   = m2r;
        MemRead_i    = mr;
        MemWrite_i   = mw;
        ALUres_i     = alu;
        WriteData_i  = wd;
        RegisterRd_i = rd;
        #1;
    endtask

    task automatic set_ack(input logic a, input logic [31:0] d);
        mem_bus.ack   = a;
        mem_bus.rdata = d;
        #1;
    endtask

    initial begin
        int req_cycles;
        int stall_cycles;

        rst_i = 1'b0;
        set_ack(1'b0, 32'h0);
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        repeat (2) step();
        check("reset_stall", {31'b0, stall_o}, 32'd0);
        check("reset_req", {31'b0, mem_bus.req}, 32'd0);
        check("reset_rdata", ReadData_o, 32'h0);
        check("reset_err", {31'b0, err_o}, 32'd0);
        rst_i = 1'b1;

        // add: passthrough, no stall, no request
        step();
        set_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5);
        check("add_stall", {31'b0, stall_o}, 32'd0);
        check("add_req", {31'b0, mem_bus.req}, 32'd0);
        check("add_regwrite", {31'b0, RegWrite_o}, 32'd1);
        check("add_rd", {27'b0, RegisterRd_o}, 32'd5);
        check("add_alures", ALUres_o, 32'h10);
        step();
        check("add_req_next", {31'b0, mem_bus.req}, 32'd0);

        // lw 0x40, ack after 2 wait cycles
        set_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7);
        stall_cycles = 0;
        check("lw_idle_regwrite", {31'b0, RegWrite_o}, 32'd0);
        check("lw_idle_req", {31'b0, mem_bus.req}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) set_ack(1'b1, 32'h1234_5678);
            if (stall_o) stall_cycles++;
            if (c > 0) begin
                check($sformatf("lw_access%0d_req", c), {31'b0, mem_bus.req}, 32'd1);
                check($sformatf("lw_access%0d_addr", c), mem_bus.addr, 32'h40);
                check($sformatf("lw_access%0d_regwrite", c), {31'b0, RegWrite_o}, 32'd0);
            end
            step();
            set_ack(1'b0, 32'h0);
        end
        check("lw_stall_cycles", stall_cycles, 32'd4);
        check("lw_done_stall", {31'b0, stall_o}, 32'd0);
        check("lw_done_req", {31'b0, mem_bus.req}, 32'd0);
        check("lw_done_regwrite", {31'b0, RegWrite_o}, 32'd1);
        check("lw_done_rdata", ReadData_o, 32'h1234_5678);
        step();

        // sw 0x44 data 0xCAFE, immediate ack
        set_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'hCAFE, 5'd0);
        check("sw_idle_stall", {31'b0, stall_o}, 32'd1);
        step();
        check("sw_req", {31'b0, mem_bus.req}, 32'd1);
        check("sw_we", {31'b0, mem_bus.we}, 32'd1);
        check("sw_wdata", mem_bus.wdata, 32'hCAFE);
        check("sw_addr", mem_bus.addr, 32'h44);
        set_ack(1'b1, 32'hBAD0_BAD0);
        step();
        set_ack(1'b0, 32'h0);
        check("sw_done_stall", {31'b0, stall_o}, 32'd0);
        check("sw_done_rdata", ReadData_o, 32'h1234_5678);
        step();

        // stray ack in IDLE is ignored
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        set_ack(1'b1, 32'hFFFF_FFFF);
        step();
        set_ack(1'b0, 32'h0);
        check("stray_ack_rdata", ReadData_o, 32'h1234_5678);
        check("stray_ack_req", {31'b0, mem_bus.req}, 32'd0);

        // back-to-back lw 0x80, lw 0x84
        set_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd1);
        step();
        check("b2b_a_req", {31'b0, mem_bus.req}, 32'd1);
        set_ack(1'b1, 32'h1111);
        step();
        set_ack(1'b0, 32'h0);
        check("b2b_a_done_req", {31'b0, mem_bus.req}, 32'd0);
        check("b2b_a_done_stall", {31'b0, stall_o}, 32'd0);
        check("b2b_a_rdata", ReadData_o, 32'h1111);
        step();
        set_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 5'd2);
        check("b2b_b_idle_stall", {31'b0, stall_o}, 32'd1);
        check("b2b_b_idle_req", {31'b0, mem_bus.req}, 32'd0);
        step();
        check("b2b_b_req", {31'b0, mem_bus.req}, 32'd1);
        check("b2b_b_addr", mem_bus.addr, 32'h84);
        set_ack(1'b1, 32'h2222);
        step();
        set_ack(1'b0, 32'h0);
        check("b2b_b_rdata", ReadData_o, 32'h2222);
        step();

        // reset during ACCESS
        set_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h90, 32'h0, 5'd3);
        step();
        check("rst_pre_req", {31'b0, mem_bus.req}, 32'd1);
        rst_i = 1'b0;
        #1;
        check("rst_mid_req", {31'b0, mem_bus.req}, 32'd0);
        check("rst_mid_stall", {31'b0, stall_o}, 32'd0);
        check("rst_mid_rdata", ReadData_o, 32'h0);
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        rst_i = 1'b1;
        step();
        check("rst_after_req", {31'b0, mem_bus.req}, 32'd0);
        check("rst_after_rdata", ReadData_o, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // lw with no ack: abort after 16 ACCESS cycles
        set_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 5'd4);
        step();
        req_cycles = 0;
        for (int c = 0; c < 40 && mem_bus.req; c++) begin
            req_cycles++;
            step();
        end
        check("to_access_cycles", req_cycles, 32'd16);
        check("to_done_stall", {31'b0, stall_o}, 32'd0);
        check("to_rdata", ReadData_o, 32'hDEAD_BEEF);
        check("to_err", {31'b0, err_o}, 32'd1);
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        repeat (3) step();
        check("to_err_sticky", {31'b0, err_o}, 32'd1);
`else
        // without the timeout feature an unacknowledged access waits indefinitely
        set_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 5'd4);
        step();
        req_cycles = 0;
        for (int c = 0; c < 24 && mem_bus.req; c++) begin
            req_cycles++;
            step();
        end
        check("noto_still_waiting", req_cycles, 32'd24);
        check("noto_err", {31'b0, err_o}, 32'd0);
        set_ack(1'b1, 32'h3333);
        step();
        set_ack(1'b0, 32'h0);
        check("noto_rdata", ReadData_o, 32'h3333);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
